// File: rtl/seq_divider_20by10.sv
// Sequential unsigned restoring divider: 2N-bit dividend by N-bit divisor, one quotient bit per clock.
// Handshake: start is taken only in IDLE with done low; busy is high from the accept edge to the result edge, and done pulses once.
module seq_divider_20by10 #(
    parameter int N = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] Y,
    input  logic [N-1:0]   B,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] Q,
    output logic [N-1:0]   R,
    output logic           dz,
    output logic [1:0]     dbg_state
);

    localparam int CW = $clog2(2 * N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DZ   = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t          state;
    logic [2*N-1:0]  dvd;
    logic [N-1:0]    div;
    logic [N-1:0]    rem;
    logic [CW-1:0]   cnt;

    logic [N:0]      rem_sh;
    logic            q_bit;
    logic [N-1:0]    rem_nx;
    logic [2*N-1:0]  dvd_nx;
    logic            last_iter;

    // The partial remainder stays below div, so the N-bit subtraction result is exact.
    always_comb begin
        rem_sh    = {rem, dvd[2*N-1]};
        q_bit     = (rem_sh >= {1'b0, div});
        rem_nx    = q_bit ? (rem_sh[N-1:0] - div) : rem_sh[N-1:0];
        dvd_nx    = {dvd[2*N-2:0], q_bit};
        last_iter = (cnt == CW'(2 * N - 1));
    end

    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            Q     <= '0;
            R     <= '0;
            dz    <= 1'b0;
            dvd   <= '0;
            div   <= '0;
            rem   <= '0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !done) begin
                        dvd   <= Y;
                        div   <= B;
                        rem   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= (B == '0) ? DZ : RUN;
                    end
                end
                RUN: begin
                    // The dividend register doubles as the quotient shift register.
                    dvd <= dvd_nx;
                    rem <= rem_nx;
                    cnt <= cnt + CW'(1);
                    if (last_iter) begin
                        Q     <= dvd_nx;
                        R     <= rem_nx;
                        dz    <= 1'b0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= FIN;
                    end
                end
                DZ: begin
                    Q     <= '1;
                    R     <= dvd[N-1:0];
                    dz    <= 1'b1;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_20by10.sv
// Directed and randomised checks of the sequential divider: latency, handshake gap, reset, divide-by-zero.
module tb_seq_divider_20by10;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [19:0] y;
    logic [9:0]  b;
    logic        busy;
    logic        done;
    logic [19:0] q;
    logic [9:0]  r;
    logic        dz;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [19:0] last_q;
    logic [9:0]  last_r;
    logic        last_dz;

    seq_divider_20by10 #(.N(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .Y         (y),
        .B         (b),
        .busy      (busy),
        .done      (done),
        .Q         (q),
        .R         (r),
        .dz        (dz),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drives a request and counts edges until busy rises; inputs are scrambled after acceptance.
    task automatic start_op(input logic [19:0] yv, input logic [9:0] bv, input int exp_edges, input string tag);
        int edges;
        edges = 0;
        y     = yv;
        b     = bv;
        start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (busy) break;
            check({tag, "_done_fall"}, {31'd0, done}, 32'd0);
        end
        start = 1'b0;
        y     = 20'($urandom_range(0, 1048575));
        b     = 10'($urandom_range(0, 1023));
        check({tag, "_accept_edges"}, edges, exp_edges);
    endtask

    // Waits for done, checking latency and result; optionally injects an ignored start at inj_cyc.
    task automatic wait_done(input int exp_lat, input logic [19:0] eq, input logic [9:0] er,
                             input logic edz, input int inj_cyc, input string tag);
        int lat;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (c == inj_cyc + 1) start = 1'b0;
            if (done) begin
                lat = c;
                break;
            end
            if (c == inj_cyc) begin
                start = 1'b1;
                y     = 20'd9;
                b     = 10'd3;
            end
            if (c == exp_lat / 2) begin
                check({tag, "_q_hold"}, {12'd0, q}, {12'd0, last_q});
                check({tag, "_busy_mid"}, {31'd0, busy}, 32'd1);
            end
        end
        start = 1'b0;
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_q"}, {12'd0, q}, {12'd0, eq});
        check({tag, "_r"}, {22'd0, r}, {22'd0, er});
        check({tag, "_dz"}, {31'd0, dz}, {31'd0, edz});
        check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        last_q  = eq;
        last_r  = er;
        last_dz = edz;
    endtask

    initial begin
        logic [9:0]  ra;
        logic [9:0]  rb;
        logic [9:0]  rr;
        logic [19:0] ry;

        rst   = 1'b1;
        start = 1'b0;
        y     = '0;
        b     = '0;
        last_q  = '0;
        last_r  = '0;
        last_dz = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_q", {12'd0, q}, 32'd0);
        check("rst_r", {22'd0, r}, 32'd0);
        check("rst_dz", {31'd0, dz}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        start_op(20'd1000, 10'd7, 1, "t1");
        wait_done(20, 20'd142, 10'd6, 1'b0, 0, "t1");

        start_op(20'd1046529, 10'd1023, 2, "t2a");
        wait_done(20, 20'd1023, 10'd0, 1'b0, 0, "t2a");
        start_op(20'd1048575, 10'd1, 2, "t2b");
        wait_done(20, 20'd1048575, 10'd0, 1'b0, 0, "t2b");
        start_op(20'd5, 10'd1023, 2, "t2c");
        wait_done(20, 20'd0, 10'd5, 1'b0, 0, "t2c");

        start_op(20'd12345, 10'd0, 2, "t3");
        wait_done(1, 20'hFFFFF, 10'd57, 1'b1, 0, "t3");

        start_op(20'd1000, 10'd7, 2, "t4");
        wait_done(20, 20'd142, 10'd6, 1'b0, 5, "t4");
        repeat (3) @(posedge clk);
        #1;
        check("t4_no_restart", {31'd0, busy}, 32'd0);

        start_op(20'd1000, 10'd7, 1, "t5");
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_done", {31'd0, done}, 32'd0);
        check("t5_q", {12'd0, q}, 32'd0);
        check("t5_r", {22'd0, r}, 32'd0);
        check("t5_dz", {31'd0, dz}, 32'd0);
        last_q  = '0;
        last_r  = '0;
        last_dz = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        start_op(20'd77, 10'd10, 1, "t5b");
        wait_done(20, 20'd7, 10'd7, 1'b0, 0, "t5b");

        for (int i = 0; i < 1000; i++) begin
            ra = 10'($urandom_range(0, 1023));
            rb = 10'($urandom_range(1, 1023));
            rr = 10'($urandom_range(0, int'(rb) - 1));
            ry = 20'(ra) * 20'(rb) + 20'(rr);
            start_op(ry, rb, 2, "t6");
            wait_done(20, 20'(ra), rr, 1'b0, 0, "t6");
        end

        @(posedge clk);
        #1;
        check("final_done_low", {31'd0, done}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
